// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider for the EX stage (one bit per cycle).
// Define MULDIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluCnt,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] ALU_MUL = 4'b1100;
  localparam logic [3:0] ALU_DIV = 4'b1110;
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);
`ifdef MULDIV_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic                 dbz_q, dbz_d;
  logic                 neg_q, neg_d, rneg_q, rneg_d;
  logic                 sign_a_s, sign_b_s, accept_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s;
  logic [WIDTH:0]       mul_sum_s, div_shift_s, div_trial_s;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic n);
    cond_neg_w = n ? (~x + ONE_W) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
    cond_neg_2w = n ? (~x + ONE_2W) : x;
  endfunction

  assign busy        = (state_q == MUL) || (state_q == DIV);
  assign done        = (state_q == DONE);
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

  // Operand magnitudes and the per-cycle multiply/divide step.
  always_comb begin
    sign_a_s    = SIGNED_EN & opA[WIDTH-1];
    sign_b_s    = SIGNED_EN & opB[WIDTH-1];
    accept_s    = start & ~flush;
    mag_a_s     = cond_neg_w(opA, sign_a_s);
    mag_b_s     = cond_neg_w(opB, sign_b_s);
    // High half accumulates; low half holds the not-yet-consumed multiplier bits.
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Remainder in the high half, dividend/quotient shifting through the low half.
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opb_q};
  end

  // Next-state, datapath and result-commit logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (aluCnt == ALU_MUL || (aluCnt == ALU_DIV && opB != {WIDTH{1'b0}}))) begin
          state_d = (aluCnt == ALU_MUL) ? MUL : DIV;
          count_d = {CW{1'b0}};
          acc_d   = {{WIDTH{1'b0}}, mag_a_s};
          opb_d   = mag_b_s;
          dbz_d   = 1'b0;
          neg_d   = sign_a_s ^ sign_b_s;
          rneg_d  = sign_a_s;
        end else if (accept_s && aluCnt == ALU_DIV) begin
          state_d  = DONE;
          res_lo_d = {WIDTH{1'b1}};
          res_hi_d = opA;
          dbz_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        count_d = count_q + CW'(1);
        acc_d   = {mul_sum_s, acc_q[WIDTH-1:1]};
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == LAST) begin
          state_d              = DONE;
          {res_hi_d, res_lo_d} = cond_neg_2w(acc_d, neg_q);
        end else begin
          state_d = MUL;
        end
      end
      DIV: begin
        count_d = count_q + CW'(1);
        if (!div_trial_s[WIDTH]) begin
          acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == LAST) begin
          state_d  = DONE;
          res_lo_d = cond_neg_w(acc_d[WIDTH-1:0], neg_q);
          res_hi_d = cond_neg_w(acc_d[2*WIDTH-1:WIDTH], rneg_q);
        end else begin
          state_d = DIV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32); honours MULDIV_SIGNED_EN.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [3:0]  aluCnt;
  logic [31:0] opA, opB;
  logic        busy, done, div_by_zero;
  logic [31:0] result_lo, result_hi;
  int tests = 0;
  int fails = 0;
  int cyc, bcnt, dcnt;

  localparam logic [3:0] MULC = 4'b1100;
  localparam logic [3:0] DIVC = 4'b1110;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluCnt(aluCnt), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; aluCnt = alu; opA = a; opB = b;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = cycle after accept edge) in which done is seen.
  task automatic wait_done(output int c, output int b);
    c = 1; b = 0;
    while (done !== 1'b1 && c < 100) begin
      if (busy === 1'b1) b++;
      tick();
      c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; aluCnt = 4'b0000; opA = 32'd0; opB = 32'd0;
    #12;
    check("reset_outputs", {busy, done, div_by_zero, result_lo, result_hi}, {3'b000, 64'd0});
    @(negedge clk); rst = 1'b0;

    issue(MULC, 32'd7, 32'd6);
    wait_done(cyc, bcnt);
    check("mul7x6_latency", cyc, 33);
    check("mul7x6_busy_cycles", bcnt, 32);
    check("mul7x6_result", {div_by_zero, result_hi, result_lo}, {1'b0, 32'd0, 32'd42});
    tick();
    check("mul7x6_hold", {done, busy, result_lo}, {1'b0, 1'b0, 32'd42});

    issue(MULC, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, bcnt);
    check("mul_max_latency", cyc, 33);
`ifdef MULDIV_SIGNED_EN
    check("mul_max_result", {result_hi, result_lo}, {32'h00000000, 32'h00000001});
`else
    check("mul_max_result", {result_hi, result_lo}, {32'hFFFFFFFE, 32'h00000001});
`endif
    tick();

    issue(DIVC, 32'd100, 32'd7);
    wait_done(cyc, bcnt);
    check("div100_7_latency", cyc, 33);
    check("div100_7_result", {div_by_zero, result_hi, result_lo}, {1'b0, 32'd2, 32'd14});
    tick();

    issue(DIVC, 32'd5, 32'd0);
    wait_done(cyc, bcnt);
    check("div0_latency", cyc, 1);
    check("div0_busy_cycles", bcnt, 0);
    check("div0_result", {div_by_zero, result_hi, result_lo}, {1'b1, 32'd5, 32'hFFFFFFFF});
    // start raised in the done cycle must be dropped, not queued
    start = 1'b1; aluCnt = MULC; opA = 32'd2; opB = 32'd3;
    tick();
    check("start_in_done_ignored", {busy, done, div_by_zero}, 3'b001);
    start = 1'b0;
    tick();
    check("no_queueing", {busy, done}, 2'b00);

    issue(MULC, 32'd123, 32'd456);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mul_idle", {busy, done, div_by_zero}, 3'b000);
    check("flush_results_kept", {result_hi, result_lo}, {32'd5, 32'hFFFFFFFF});
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    check("flush_no_done", dcnt, 0);

    issue(DIVC, 32'd9, 32'd3);
    wait_done(cyc, bcnt);
    check("div9_3_latency", cyc, 33);
    check("div9_3_result", {result_hi, result_lo}, {32'd0, 32'd3});
    tick();

    @(negedge clk);
    flush = 1'b1; start = 1'b1; aluCnt = MULC; opA = 32'd2; opB = 32'd3;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_beats_start", {busy, done}, 2'b00);

    issue(DIVC, 32'd100, 32'd7);
    repeat (4) tick();
    check("div_running", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_mid_div", {busy, done, div_by_zero, result_lo, result_hi}, {3'b000, 64'd0});
    @(negedge clk); rst = 1'b0;
    issue(4'b0000, 32'd5, 32'd6);
    check("other_code_ignored", {busy, done}, 2'b00);
    tick();
    check("other_code_no_done", {busy, done, result_lo, result_hi}, {2'b00, 64'd0});

    issue(MULC, 32'hFFFFFFFD, 32'd5);
    wait_done(cyc, bcnt);
`ifdef MULDIV_SIGNED_EN
    check("mul_neg3x5", {result_hi, result_lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
`else
    check("mul_neg3x5", {result_hi, result_lo}, {32'h00000004, 32'hFFFFFFF1});
`endif
    tick();

    issue(DIVC, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, bcnt);
`ifdef MULDIV_SIGNED_EN
    check("div_neg7_2", {result_hi, result_lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
`else
    check("div_neg7_2", {result_hi, result_lo}, {32'h00000001, 32'h7FFFFFFC});
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
